// File: rtl/mux_n_1_rr_stream.sv
// N_CH-to-1 valid/ready stream mux: round-robin arbiter feeding one registered output stage.
// Optional MUX_STREAM_BURST_EN lets a winner keep the grant for up to MAX_BURST consecutive loads.
module mux_n_1_rr_stream #(
   parameter int N_CH      = 4,
   parameter int W         = 4,
   parameter int MAX_BURST = 4,
   localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [N_CH-1:0]   in_valid_i,
   input  logic [N_CH*W-1:0] in_data_i,
   output logic [N_CH-1:0]   in_ready_o,
   output logic              out_valid_o,
   output logic [W-1:0]      out_data_o,
   input  logic              out_ready_i,
   output logic [CW-1:0]     out_ch_o
);

   if (N_CH < 2 || MAX_BURST < 1) begin : g_param_chk
      $error("mux_n_1_rr_stream: needs N_CH >= 2 and MAX_BURST >= 1");
   end

   logic [CW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] win, win_nxt;
   logic [CW:0]   idx;
   logic          found, load;
   logic          out_valid_q;
   logic [W-1:0]  out_data_q;
   logic [CW-1:0] out_ch_q;

   // Rotating priority scan starting at ptr; idx never exceeds 2*N_CH-2, one subtract wraps it.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = {1'b0, ptr_q} + (CW+1)'(k);
         if (idx >= (CW+1)'(N_CH)) idx = idx - (CW+1)'(N_CH);
         if (!found && in_valid_i[idx[CW-1:0]]) begin
            found = 1'b1;
            win   = idx[CW-1:0];
         end
      end
   end

   assign win_nxt = (win == CW'(N_CH-1)) ? '0 : win + 1'b1;

   // Reset gates ready directly so no handshake can be signalled while rst_n is low.
   assign load = rst_n_i & found & (~out_valid_q | out_ready_i);

   always_comb begin
      in_ready_o      = '0;
      in_ready_o[win] = load;
   end

`ifdef MUX_STREAM_BURST_EN
   localparam int BW = $clog2(MAX_BURST + 1);
   logic [BW-1:0] cnt_q, cnt_d, cnt_inc;

   // cnt_q != 0 means ptr_q holds the channel of a burst still in progress.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      cnt_inc = (win == ptr_q && cnt_q != '0) ? cnt_q + 1'b1 : BW'(1);
      if (load) begin
         if (cnt_inc >= BW'(MAX_BURST)) begin
            ptr_d = win_nxt;
            cnt_d = '0;
         end else begin
            ptr_d = win;
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   always_comb begin
      ptr_d = ptr_q;
      if (load) ptr_d = win_nxt;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data_i[int'(win)*W +: W];
            out_ch_q    <= win;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_ch_o    = out_ch_q;

endmodule

// File: doc/mux_n_1_rr_stream.md
Name: mux_n_1_rr_stream

Overview:
- Parametrised successor to the combinational 4:1 mux: an N-channel, W-bit stream multiplexer with valid/ready handshakes.
- Selection is made by an internal round-robin arbiter, not an external sel input.
- The chosen beat is registered in a single output stage.
- Sits between several producer streams and one consumer; throughput is 1 beat/cycle, latency 1 cycle.

Parameters:
- N_CH, 4, number of input channels (>= 2, power of two not required)
- W, 4, data width per channel in bits
- MAX_BURST, 4, max consecutive grants to one channel; used only with MUX_STREAM_BURST_EN (>= 1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_CH  per-channel valid
- in_data  input  N_CH*W  channel i occupies bits [i*W +: W]
- in_ready  output  N_CH  per-channel ready; one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  W  registered beat
- out_ready  input  1  consumer accepts the beat
- out_ch  output  $clog2(N_CH)  source channel of the current out_data

Behaviour:
- Reset (rst_n low, takes effect immediately, without waiting for clk):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0; burst counter=0.
  - in_ready=0 while rst_n is low.
  - A beat held at reset is dropped.
- Load enable: load = (|in_valid) & (~out_valid | out_ready).
  - An empty register fills.
  - A full register is drained and refilled in the same cycle (no bubble).
- Arbitration, combinational:
  - Winner = first i with in_valid[i]=1, scanning ptr, ptr+1, …, N_CH-1, 0, …, ptr-1.
  - in_ready[winner] = load; all other in_ready bits = 0.
  - in_ready must not depend on in_data.
- On a clock edge with load=1:
  - out_data <= in_data[winner]; out_ch <= winner; out_valid <= 1.
  - ptr <= winner+1, wrapping N_CH-1 -> 0.
- On a clock edge with out_valid & out_ready & ~load: out_valid <= 0. out_data and out_ch keep their last values.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_ch stay stable.
  - All in_ready=0; ptr is unchanged.
- Producers hold in_data and in_valid until in_ready; a valid that drops before its handshake is legal and never loads.
- Fairness: with all channels continuously valid and no backpressure, each channel gets exactly one grant per N_CH consecutive loads.
- Single active channel: granted every cycle regardless of ptr.
- X on in_data of a non-winning channel must not propagate to out_data.

Optional Feature:
- Macro: MUX_STREAM_BURST_EN.
- Defined:
  - After a load from channel c, ptr stays at c while the burst counter < MAX_BURST, so c wins again if still valid.
  - The counter increments per load from c.
  - When the counter reaches MAX_BURST, or c is not valid at a load, ptr advances to winner+1 and the counter restarts at 1 for the new winner.
  - MAX_BURST=1 is identical to the undefined build.
- Undefined: pure round-robin as above; MAX_BURST is ignored; no counter logic is synthesised.

Test Plan (N_CH=4, W=4):
- Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000, all changing without a clk edge. Release and keep out_ready=1.
- Full round robin: in_data = {d,c,b,a}, all valid, out_ready=1 -> out_data a,b,c,d,a,b on consecutive cycles; out_ch 0,1,2,3,0,1; in_ready one-hot 0001,0010,0100,1000.
- Backpressure: out_valid=1 with out_data='hb, then out_ready=0 for 3 cycles -> out_data stays 'hb and in_ready=0000. On release, next beat is 'hc with no idle cycle.
- Wrap and skip:
  - Only ch2 valid ('hc) -> 'hc every cycle, out_ch=2.
  - Then ch0='ha and ch2 valid -> ptr=3 wraps and ch0 wins ('ha), then ch2 ('hc), alternating.
  - ch3 data='x with ch3 invalid -> out_data never X.
- Drain: single ch1 beat 'h7, then no valid -> out_valid high 1 cycle after the handshake, low the cycle after out_ready=1. out_data stays 'h7.
- Burst (MUX_STREAM_BURST_EN, MAX_BURST=2), all valid, out_ready=1 -> a,a,b,b,c,c,d,d,a. If ch1 deasserts after one beat -> a,a,b,c,c.
